// File: rtl/mem_stream_reader_pkg.sv
// Shared definitions for the memory stream reader: memory geometry, transfer
// sizing defaults and the controller state encoding.
package mem_stream_reader_pkg;

    localparam int MEM_ADDR_W   = 7;
    localparam int MEM_DATA_W   = 32;
    localparam int MEM_DEPTH    = 1 << MEM_ADDR_W;
    localparam int XFER_LEN_W   = 8;
    localparam int RD_BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Requested lengths beyond the memory depth collapse to one full sweep.
    function automatic int sat_len(input int req_len, input int max_len);
        return (req_len > max_len) ? max_len : req_len;
    endfunction

endpackage

// File: rtl/mem_stream_reader_read_skid_buf.sv
// Small FIFO of {last, data} words between the SRAM read port and the stream
// output; the producer guarantees it never pushes into a full buffer.
module mem_stream_reader_read_skid_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              push_last,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [CNT_W-1:0]  count,
    output logic              head_valid,
    output logic              head_last,
    output logic [DATA_W-1:0] head_data
);

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  last_q;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: storage is cleared as well so head_data reads zero out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            last_q <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                data_q[wr_ptr] <= push_data;
                last_q[wr_ptr] <= push_last;
                wr_ptr         <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_valid = (count != '0);
    assign head_last  = head_valid & last_q[rd_ptr];
    assign head_data  = data_q[rd_ptr];

endmodule

// File: rtl/mem_stream_reader.sv
// Sweeps a wrapping address range on the SRAM read port and streams the words
// out over valid/ready, hiding the 1-cycle read latency behind a skid buffer.
module mem_stream_reader
    import mem_stream_reader_pkg::*;
#(
    parameter int ADDR_W    = MEM_ADDR_W,
    parameter int DATA_W    = MEM_DATA_W,
    parameter int LEN_W     = XFER_LEN_W,
    parameter int BUF_DEPTH = RD_BUF_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    state_t            state;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] last_addr;
    logic [LEN_W-1:0]  issue_left;
    logic [LEN_W-1:0]  eff_len;
    logic              inflight;
    logic              inflight_last;
    logic [CNT_W-1:0]  buf_count;
    logic              pop;
    logic              issue;
    logic              final_issue;

    assign eff_len = LEN_W'(sat_len(int'(len), DEPTH));
    assign pop     = out_valid & out_ready;

    // A read may only go out if its word is guaranteed a buffer slot when it lands.
    assign issue = (state == ST_ISSUE) &&
                   (int'(buf_count) + int'(inflight) < BUF_DEPTH + int'(pop));
    assign final_issue = issue && (issue_left == LEN_W'(1));

    // Between issues the port keeps showing the last address read.
    assign mem_addr = issue ? rd_addr : last_addr;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            rd_addr       <= '0;
            last_addr     <= '0;
            issue_left    <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            // NOTE: all state here uses <=, so every branch sees pre-edge values.
            inflight      <= issue;
            inflight_last <= final_issue;
            if (issue) begin
                last_addr  <= rd_addr;
                rd_addr    <= rd_addr + ADDR_W'(1);
                issue_left <= issue_left - LEN_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy       <= 1'b1;
                        rd_addr    <= base_addr;
                        issue_left <= eff_len;
                        if (eff_len == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (final_issue) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (pop && out_last) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    mem_stream_reader_read_skid_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clock      (clock),
        .reset      (reset),
        .push       (inflight),
        .push_last  (inflight_last),
        .push_data  (mem_rdata),
        .pop        (pop),
        .count      (buf_count),
        .head_valid (out_valid),
        .head_last  (out_last),
        .head_data  (out_data)
    );

endmodule
